// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display back end:
// conversion FSM states, conversion/digit sizes and seven-segment patterns.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    BCD,
    LOAD
  } conv_state_e;

  localparam int CONV_LEN   = 32;
  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles light nothing.
module seven_seg_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display back end: cycle count -> centiseconds (restoring divider)
// -> 4 BCD digits (double-dabble) -> multiplexed active-low 7-segment display.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned CYC_PER_CS = 1_000_000,
  parameter int unsigned SCAN_CYC   = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] count_i,
  output logic [15:0] bcd_o,
  output logic        upd_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam logic [32:0] DIVISOR  = {1'b0, 32'(CYC_PER_CS)};
  localparam logic [4:0]  LAST_BIT = 5'(CONV_LEN - 1);
  localparam logic [31:0] SCAN_MAX = 32'(SCAN_CYC - 1);

  conv_state_e state_q, state_d;
  logic [31:0] sample_q, sample_d;
  logic [31:0] quot_q, quot_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  bitCnt_q, bitCnt_d;
  logic [15:0] bcdWork_q, bcdWork_d;
  logic [15:0] bcd_q, bcd_d;
  logic        upd_q, upd_d;

  logic [32:0] trial;
  logic [15:0] bcdAdj;

  logic [31:0] scanCnt_q, scanCnt_d;
  logic [1:0]  digitIdx_q, digitIdx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  nibble;
  logic [6:0]  segRaw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      bitCnt_q  <= '0;
      bcdWork_q <= '0;
      bcd_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      bitCnt_q  <= bitCnt_d;
      bcdWork_q <= bcdWork_d;
      bcd_q     <= bcd_d;
      upd_q     <= upd_d;
    end
  end

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  // Carries out of the top digit are dropped, giving quotient mod 10000.
  always_comb begin
    bcdAdj = bcdWork_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcdWork_q[i*4 +: 4] >= 4'd5) begin
        bcdAdj[i*4 +: 4] = bcdWork_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign trial = {rem_q[31:0], sample_q[31]};

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    bitCnt_d  = bitCnt_q;
    bcdWork_d = bcdWork_q;
    bcd_d     = bcd_q;
    upd_d     = 1'b0;
    case (state_q)
      IDLE: begin
        sample_d = count_i;
        quot_d   = '0;
        rem_d    = '0;
        bitCnt_d = '0;
        state_d  = DIV;
      end
      DIV: begin
        sample_d = {sample_q[30:0], 1'b0};
        if (trial >= DIVISOR) begin
          rem_d  = trial - DIVISOR;
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = trial;
          quot_d = {quot_q[30:0], 1'b0};
        end
        bitCnt_d = bitCnt_q + 5'd1;
        if (bitCnt_q == LAST_BIT) begin
          bitCnt_d  = '0;
          bcdWork_d = '0;
          state_d   = BCD;
        end
      end
      BCD: begin
        bcdWork_d = {bcdAdj[14:0], quot_q[31]};
        quot_d    = {quot_q[30:0], 1'b0};
        bitCnt_d  = bitCnt_q + 5'd1;
        if (bitCnt_q == LAST_BIT) begin
          bitCnt_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = bcdWork_q;
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display outputs are computed from the next digit index so they
  // change on the same edge as the index itself.
  always_comb begin
    scanCnt_d  = scanCnt_q + 32'd1;
    digitIdx_d = digitIdx_q;
    if (scanCnt_q >= SCAN_MAX) begin
      scanCnt_d  = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end
    case (digitIdx_d)
      2'd0:    nibble = bcd_q[3:0];
      2'd1:    nibble = bcd_q[7:4];
      2'd2:    nibble = bcd_q[11:8];
      default: nibble = bcd_q[15:12];
    endcase
    an_d  = ~(4'b0001 << digitIdx_d);
    seg_d = segRaw;
    if (digitIdx_d == 2'd3 && bcd_q[15:12] == 4'd0) begin
      seg_d = SEG_BLANK;
    end
    dp_d = (digitIdx_d != 2'd2);
  end

  seven_seg_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (segRaw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanCnt_q  <= '0;
      digitIdx_q <= '0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_0;
      dp_q       <= 1'b1;
    end else begin
      scanCnt_q  <= scanCnt_d;
      digitIdx_q <= digitIdx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bcd_o = bcd_q;
  assign upd_o = upd_q;
  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed self-checking bench for stopwatch_display with CYC_PER_CS=10,
// SCAN_CYC=4; every expected value is hand-computed from the count applied.
module tb_stopwatch_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] count_i = '0;
  logic [15:0] bcd_o;
  logic        upd_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int testsRun = 0;
  int testsFailed = 0;

  stopwatch_display #(
    .CYC_PER_CS (10),
    .SCAN_CYC   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_i (count_i),
    .bcd_o   (bcd_o),
    .upd_o   (upd_o),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o)
  );

  always #5 clk = ~clk;

  // Advance edge by edge until upd is seen; n is the number of edges taken.
  task automatic waitUpd(output bit found, output int n);
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (upd_o) found = 1'b1;
    end
  endtask

  // Wait for a fresh selection of the target digit (leave it, then re-enter).
  task automatic waitAn(input logic [3:0] target, output bit found);
    int n;
    n = 0;
    while (an_o == target && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    while (an_o != target && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    found = (an_o == target) && (n < 40);
  endtask

  task automatic test_reset();
    bit found;
    int n;
    rst_n = 1'b0;
    count_i = 32'd0;
    #23;
    testsRun++;
    if (an_o !== 4'b1110) begin
      testsFailed++;
      $display("[TB] FAIL reset_an: got %b expected 1110", an_o);
    end
    testsRun++;
    if (seg_o !== 7'b1000000) begin
      testsFailed++;
      $display("[TB] FAIL reset_seg: got %b expected 1000000", seg_o);
    end
    testsRun++;
    if (dp_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_dp: got %b expected 1", dp_o);
    end
    testsRun++;
    if (bcd_o !== 16'h0000 || upd_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bcd_upd: got bcd=%h upd=%b expected 0000/0", bcd_o, upd_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitUpd(found, n);
    testsRun++;
    if (!found || n != 66) begin
      testsFailed++;
      $display("[TB] FAIL first_upd_latency: got %0d edges (found=%0b) expected 66", n, found);
    end
    testsRun++;
    if (bcd_o !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL first_bcd: got %h expected 0000", bcd_o);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (upd_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL upd_one_cycle: got %b expected 0", upd_o);
    end
  endtask

  task automatic test_nominal();
    bit found;
    int n;
    int bad;
    count_i = 32'd12345;
    waitUpd(found, n);
    waitUpd(found, n);
    testsRun++;
    if (!found || n != 66) begin
      testsFailed++;
      $display("[TB] FAIL upd_period: got %0d edges (found=%0b) expected 66", n, found);
    end
    testsRun++;
    if (bcd_o !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL nominal_bcd: got %h expected 1234", bcd_o);
    end
    waitAn(4'b0111, found);
    testsRun++;
    if (!found || seg_o !== 7'b1111001) begin
      testsFailed++;
      $display("[TB] FAIL nominal_digit3: got seg=%b (found=%0b) expected 1111001", seg_o, found);
    end
    waitAn(4'b1110, found);
    testsRun++;
    if (!found || seg_o !== 7'b0011001) begin
      testsFailed++;
      $display("[TB] FAIL nominal_digit0: got seg=%b (found=%0b) expected 0011001", seg_o, found);
    end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (dp_o !== ((an_o == 4'b1011) ? 1'b0 : 1'b1)) bad++;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL nominal_dp: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_wrap();
    bit found;
    int n;
    count_i = 32'd123456;
    waitUpd(found, n);
    waitUpd(found, n);
    testsRun++;
    if (!found || bcd_o !== 16'h2345) begin
      testsFailed++;
      $display("[TB] FAIL wrap_123456: got %h (found=%0b) expected 2345", bcd_o, found);
    end
    count_i = 32'hFFFF_FFFF;
    waitUpd(found, n);
    waitUpd(found, n);
    testsRun++;
    if (!found || bcd_o !== 16'h6729) begin
      testsFailed++;
      $display("[TB] FAIL wrap_max: got %h (found=%0b) expected 6729", bcd_o, found);
    end
  endtask

  task automatic test_blank_scan();
    bit found;
    int n;
    logic [3:0] anSeq [4];
    logic [6:0] segSeq [4];
    logic [3:0] cur;
    logic [3:0] nxt;
    anSeq[0] = 4'b1110; anSeq[1] = 4'b1101; anSeq[2] = 4'b1011; anSeq[3] = 4'b0111;
    segSeq[0] = 7'b0000010; segSeq[1] = 7'b0010010;
    segSeq[2] = 7'b1000000; segSeq[3] = 7'b1111111;
    count_i = 32'd567;
    waitUpd(found, n);
    waitUpd(found, n);
    testsRun++;
    if (!found || bcd_o !== 16'h0056) begin
      testsFailed++;
      $display("[TB] FAIL blank_bcd: got %h (found=%0b) expected 0056", bcd_o, found);
    end
    waitAn(4'b1110, found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL scan_start: got an=%b expected 1110", an_o);
    end
    for (int s = 0; s < 4; s++) begin
      cur = anSeq[s];
      nxt = anSeq[(s + 1) % 4];
      testsRun++;
      if (seg_o !== segSeq[s] || dp_o !== ((s == 2) ? 1'b0 : 1'b1)) begin
        testsFailed++;
        $display("[TB] FAIL scan_seg_%0d: got seg=%b dp=%b expected %b dp=%b",
                 s, seg_o, dp_o, segSeq[s], (s == 2) ? 1'b0 : 1'b1);
      end
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      testsRun++;
      if (an_o !== cur) begin
        testsFailed++;
        $display("[TB] FAIL scan_hold_%0d: got an=%b expected %b", s, an_o, cur);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (an_o !== nxt) begin
        testsFailed++;
        $display("[TB] FAIL scan_step_%0d: got an=%b expected %b", s, an_o, nxt);
      end
    end
  endtask

  task automatic test_mid_change();
    bit found;
    int n;
    count_i = 32'd100;
    waitUpd(found, n);
    // Next edge samples 100; change the input 20 cycles after that sample.
    repeat (21) begin
      @(posedge clk);
      #1;
    end
    count_i = 32'd900;
    waitUpd(found, n);
    testsRun++;
    if (!found || bcd_o !== 16'h0010) begin
      testsFailed++;
      $display("[TB] FAIL mid_change_first: got %h (found=%0b) expected 0010", bcd_o, found);
    end
    waitUpd(found, n);
    testsRun++;
    if (!found || bcd_o !== 16'h0090) begin
      testsFailed++;
      $display("[TB] FAIL mid_change_second: got %h (found=%0b) expected 0090", bcd_o, found);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n;
    int spurious;
    count_i = 32'd4321;
    waitUpd(found, n);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (an_o !== 4'b1110 || seg_o !== 7'b1000000 || dp_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_display: got an=%b seg=%b dp=%b expected 1110/1000000/1",
               an_o, seg_o, dp_o);
    end
    testsRun++;
    if (bcd_o !== 16'h0000 || upd_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_bcd: got bcd=%h upd=%b expected 0000/0", bcd_o, upd_o);
    end
    spurious = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (upd_o !== 1'b0) spurious++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitUpd(found, n);
    testsRun++;
    if (spurious != 0 || !found || n != 66) begin
      testsFailed++;
      $display("[TB] FAIL midreset_latency: got %0d edges spurious=%0d expected 66/0", n, spurious);
    end
    testsRun++;
    if (bcd_o !== 16'h0432) begin
      testsFailed++;
      $display("[TB] FAIL midreset_bcd_after: got %h expected 0432", bcd_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrap();
    test_blank_scan();
    test_mid_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display back end for the stopwatch. Samples the free-running 32-bit stopwatch cycle count and converts it to centiseconds with an iterative divider. Converts the result to four BCD digits (SS.hh) with sequential double-dabble. Drives a time-multiplexed, active-low 4-digit seven-segment display on the lab board.

## Interface
- CYC_PER_CS, 1_000_000, clk cycles per displayed centisecond (100 MHz → 10 ms); legal range 1..2^32-1.
- SCAN_CYC, 100_000, clk cycles each digit stays selected; legal range ≥1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- count  in  32  raw stopwatch count (clk cycles elapsed), sampled once per conversion.
- bcd  out  16  last converted value, 4 BCD digits; [3:0] = hundredths, [15:12] = tens of seconds.
- upd  out  1  one-cycle pulse when bcd updates.
- an  out  4  digit enables, active-low; an[0] = rightmost digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.

## Operation
- Conversion FSM states: IDLE, DIV, BCD, LOAD.
  - IDLE: latch count into sample register → DIV.
  - DIV: restoring division of sample by CYC_PER_CS, one quotient bit per cycle, MSB first, 32 cycles → BCD.
  - BCD: double-dabble of the 32-bit quotient into a 16-bit BCD register, 32 cycles.
    - Each cycle, first add 3 to every digit ≥5, then shift in the next quotient bit, MSB first.
    - Carry out of digit 3 is discarded, so bcd = quotient mod 10000.
  - LOAD: copy BCD register to bcd and assert upd for this cycle → IDLE.
- Conversions run back-to-back indefinitely; there is no start input.
- Changes on count outside the IDLE cycle are ignored until the next sample.
- Remainder is discarded; display truncates, never rounds.
- Internal widths:
  - 32-bit quotient.
  - 33-bit partial remainder, so no overflow for any divisor.
- Scan:
  - 2-bit digit index advances 0→1→2→3→0 every SCAN_CYC cycles, independent of the FSM.
  - an is one-hot low on the selected digit.
  - seg shows the selected digit of bcd through the hex-to-seven-segment decode.
  - Non-decimal nibbles (impossible by construction) decode to all segments off.
- Leading-zero blank: when digit 3 is selected and bcd[15:12]==0, seg = 7'b1111111.
- dp = 0 only while digit 2 is selected (SS.hh); 1 otherwise.

## Timing
- Reset values:
  - FSM = IDLE; bcd = 16'h0000; upd = 0.
  - Digit index = 0, an = 4'b1110, seg = 7'b1000000 ("0"), dp = 1.
  - Scan counter = 0, sample/quotient/remainder = 0.
- Conversion period is exactly 66 cycles: 1 IDLE + 32 DIV + 32 BCD + 1 LOAD.
- upd pulses every 66 cycles. The first pulse occurs 66 cycles after the first clk edge following rst_n release.
- Sampled count to bcd/upd: 65 cycles after the IDLE sampling edge.
- an, seg and dp are registered and change on the same edge as the digit index. bcd changes reach seg within 1 cycle while that digit is selected.
- rst_n asserted mid-conversion: abort immediately, all outputs to reset values, no upd. Restart from IDLE after release.
- Boundary cases:
  - CYC_PER_CS = 1: quotient = count.
  - count = 0xFFFFFFFF: legal, no special handling.

## Structure
- Package stopwatch_pkg holds:
  - the FSM state enum (IDLE, DIV, BCD, LOAD);
  - localparams for conversion length (32) and digit count (4);
  - seven-segment constants: SEG_BLANK = 7'b1111111 and the 0-9 patterns.
- One sub-module: seven_seg_decode, combinational, 4-bit nibble in → 7-bit active-low segments out. It is reused by other labs.
- Divider, double-dabble and scan logic stay in stopwatch_display.

## Test plan
Bench parameters: CYC_PER_CS=10, SCAN_CYC=4.
- Reset: rst_n low → an=4'b1110, seg=7'b1000000, dp=1, bcd=16'h0000, upd=0. First upd exactly 66 cycles after release.
- Nominal: count held at 12345 → next upd with bcd=16'h1234. On digit 3, seg = "1" pattern 7'b1111001. dp=0 only while an=4'b1011.
- Wrap: count=123456 → bcd=16'h2345. Count=0xFFFFFFFF → quotient 429496729, bcd=16'h6729.
- Blanking and scan: count=567 → bcd=16'h0056.
  - an steps 1110→1101→1011→0111 every 4 cycles.
  - Digit 3 seg=7'b1111111.
  - Digit 2 shows "0" with dp=0.
- Mid-conversion change: count switched from 100 to 900 twenty cycles after an IDLE sample → that conversion yields 16'h0010; the next yields 16'h0090.
- Reset mid-conversion: rst_n pulsed low during DIV → outputs return to reset values, no spurious upd. Next upd 66 cycles after release with the correct value.
